blocking_channel_fifo: RTL and testbench

//  Peer end of the sync/notify blocking-port protocol. A producer's blocking

---
 rtl/blocking_channel_fifo.sv | 83 ++++++++
 tb/tb_blocking_channel_fifo.sv | 168 ++++++++++++++++
 2 files changed

// File: rtl/blocking_channel_fifo.sv
// Blocking sync/notify channel: DEPTH-entry FIFO with registered head word,
// occupancy count and high-water mark.
module blocking_channel_fifo #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned DEPTH  = 4,
  localparam int unsigned CNT_W = $clog2(DEPTH) + 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              wr_notify,
  output logic              wr_sync,
  output logic [DATA_W-1:0] rd_data,
  input  logic              rd_notify,
  output logic              rd_sync,
  output logic [CNT_W-1:0]  count,
  output logic [CNT_W-1:0]  hwm
);

  localparam int unsigned PTR_W = $clog2(DEPTH);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic [CNT_W-1:0]  hwm_q, hwm_d;
  logic [DATA_W-1:0] rd_data_q, rd_data_d;
  logic              wr_fire, rd_fire;

  // Handshakes come from registered occupancy only.
  assign wr_sync = (count_q != CNT_W'(DEPTH));
  assign rd_sync = (count_q != '0);
  assign wr_fire = wr_notify && wr_sync;
  assign rd_fire = rd_notify && rd_sync;

  always_comb begin
    wr_ptr_d = wr_fire ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
    rd_ptr_d = rd_fire ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;

    count_d = count_q;
    case ({wr_fire, rd_fire})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase

    hwm_d = (count_d > hwm_q) ? count_d : hwm_q;

    // The incoming word becomes the head when it lands where the read pointer ends up.
    if (wr_fire && (wr_ptr_q == rd_ptr_d)) begin
      rd_data_d = wr_data;
    end else begin
      rd_data_d = mem[rd_ptr_d];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      hwm_q     <= '0;
      rd_data_q <= '0;
    end else begin
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
      hwm_q     <= hwm_d;
      rd_data_q <= rd_data_d;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && wr_fire) begin
      mem[wr_ptr_q] <= wr_data;
    end
  end

  assign rd_data = rd_data_q;
  assign count   = count_q;
  assign hwm     = hwm_q;

endmodule

// File: tb/tb_blocking_channel_fifo.sv
// Bench for blocking_channel_fifo: directed literal checks plus randomized
// traffic compared every cycle against a queue-based model.
module tb_blocking_channel_fifo;

  localparam int DATA_W = 32;
  localparam int DEPTH  = 4;
  localparam int CNT_W  = $clog2(DEPTH) + 1;

  logic              clk = 1'b0;
  logic              rst;
  logic [DATA_W-1:0] wr_data;
  logic              wr_notify;
  logic              wr_sync;
  logic [DATA_W-1:0] rd_data;
  logic              rd_notify;
  logic              rd_sync;
  logic [CNT_W-1:0]  count;
  logic [CNT_W-1:0]  hwm;

  int n_checks = 0;
  int n_fail   = 0;

  // Model state
  logic [DATA_W-1:0] q[$];
  int                m_hwm = 0;

  always #5 clk = ~clk;

  blocking_channel_fifo #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .wr_data   (wr_data),
    .wr_notify (wr_notify),
    .wr_sync   (wr_sync),
    .rd_data   (rd_data),
    .rd_notify (rd_notify),
    .rd_sync   (rd_sync),
    .count     (count),
    .hwm       (hwm)
  );

  task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  // Compare all meaningful outputs against the model.
  task automatic check_model();
    cmp("model_wr_sync", 32'(wr_sync), 32'(q.size() != DEPTH));
    cmp("model_rd_sync", 32'(rd_sync), 32'(q.size() != 0));
    cmp("model_count", 32'(count), 32'(q.size()));
    cmp("model_hwm", 32'(hwm), 32'(m_hwm));
    if (q.size() > 0) cmp("model_rd_data", rd_data, q[0]);
  endtask

  // Drive one cycle from a negedge, update the model at posedge, check at next negedge.
  task automatic step(input logic r, input logic wn, input logic rn, input logic [31:0] d);
    bit wf, rf;
    rst       = r;
    wr_notify = wn;
    rd_notify = rn;
    wr_data   = d;
    @(posedge clk);
    if (r) begin
      q.delete();
      m_hwm = 0;
    end else begin
      wf = wn && (q.size() < DEPTH);
      rf = rn && (q.size() > 0);
      if (rf) void'(q.pop_front());
      if (wf) q.push_back(d);
      if (q.size() > m_hwm) m_hwm = q.size();
    end
    @(negedge clk);
    check_model();
  endtask

  initial begin
    int pw, pr;
    rst = 1'b1; wr_notify = 1'b0; rd_notify = 1'b0; wr_data = '0;
    @(negedge clk);
    step(1, 0, 0, 0);
    step(1, 0, 0, 0);

    // Reset state
    cmp("rst_wr_sync", 32'(wr_sync), 1);
    cmp("rst_rd_sync", 32'(rd_sync), 0);
    cmp("rst_count", 32'(count), 0);
    cmp("rst_hwm", 32'(hwm), 0);
    cmp("rst_rd_data", rd_data, 0);

    // Single write then read
    step(0, 1, 0, 5);
    cmp("w5_rd_sync", 32'(rd_sync), 1);
    cmp("w5_rd_data", rd_data, 5);
    cmp("w5_count", 32'(count), 1);
    step(0, 0, 1, 0);
    cmp("r5_rd_sync", 32'(rd_sync), 0);
    cmp("r5_count", 32'(count), 0);

    // Fill to full, blocked write, read releases
    for (int i = 1; i <= 4; i++) step(0, 1, 0, 32'(i));
    cmp("full_wr_sync", 32'(wr_sync), 0);
    cmp("full_count", 32'(count), 4);
    cmp("full_hwm", 32'(hwm), 4);
    step(0, 1, 0, 5);
    cmp("held_count", 32'(count), 4);
    cmp("held_rd_data", rd_data, 1);
    step(0, 0, 1, 0);
    cmp("rel_wr_sync", 32'(wr_sync), 1);
    cmp("rel_count", 32'(count), 3);
    cmp("rel_rd_data", rd_data, 2);

    // Full with both requests: only the read happens, write completes next
    step(0, 1, 0, 5);
    cmp("refill_count", 32'(count), 4);
    step(0, 1, 1, 6);
    cmp("both_full_count", 32'(count), 3);
    cmp("both_full_rd_data", rd_data, 3);
    step(0, 1, 0, 6);
    cmp("pend_count", 32'(count), 4);

    // Streaming at count=2 across pointer wrap
    step(1, 0, 0, 0);
    step(0, 1, 0, 10);
    step(0, 1, 0, 11);
    for (int i = 0; i < 10; i++) begin
      step(0, 1, 1, 32'(12 + i));
      cmp("stream_count", 32'(count), 2);
      cmp("stream_rd_data", rd_data, 32'(11 + i));
    end

    // Reset mid-transfer at count=3
    step(0, 1, 0, 22);
    cmp("pre_rst_count", 32'(count), 3);
    step(1, 1, 1, 99);
    cmp("mid_rst_count", 32'(count), 0);
    cmp("mid_rst_rd_sync", 32'(rd_sync), 0);
    cmp("mid_rst_wr_sync", 32'(wr_sync), 1);
    cmp("mid_rst_hwm", 32'(hwm), 0);
    step(0, 1, 0, 7);
    cmp("after_rst_rd_data", rd_data, 7);

    // Randomized traffic with shifting bias to visit empty and full often
    for (int c = 0; c < 3000; c++) begin
      case ((c / 100) % 4)
        0:       begin pw = 80; pr = 30; end
        1:       begin pw = 30; pr = 80; end
        2:       begin pw = 50; pr = 50; end
        default: begin pw = 90; pr = 90; end
      endcase
      step(($urandom_range(0, 199) == 0),
           ($urandom_range(0, 99) < pw),
           ($urandom_range(0, 99) < pr),
           $urandom());
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
